// File: rtl/mem_arb_pkg.sv
// ----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the memory port arbiter.
//   state_e     : arbiter FSM states (IDLE, ISSUE, RESP)
//   grant_e     : which requester owns the current transfer (NONE, FE, DM)
//   AW_DEF/DW_DEF : default address / data widths
//   be_all_ones : byte-enable mask with the lowest nbytes bits set
// ----------------------------------------------------------------------------
package mem_arb_pkg;

    localparam int AW_DEF = 32;
    localparam int DW_DEF = 32;
    // Widest byte-enable vector be_all_ones can build (DW up to 256).
    localparam int BE_MAX = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        FE   = 2'd1,
        DM   = 2'd2
    } grant_e;

    function automatic logic [BE_MAX-1:0] be_all_ones(input int nbytes);
        logic [BE_MAX-1:0] r;
        r = '0;
        for (int i = 0; i < BE_MAX; i++) begin
            if (i < nbytes) begin
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles the fetch requester, data requester and memory-side handshakes of
// the memory port arbiter.
//   modport master : the arbiter's view (takes requests, drives the memory)
//   modport slave  : the environment's view (requesters plus memory model)
// Signals:
//   fe_req/fe_addr -> fe_ack/fe_rdata               fetch requester
//   dm_req/dm_we/dm_addr/dm_wdata/dm_be -> dm_ack/dm_rdata  data requester
//   mem_req/mem_we/mem_addr/mem_wdata/mem_be <- mem_ack/mem_rdata  memory
//   err : one-cycle abort flag, coincident with the requester ack
// ----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic            fe_req;
    logic [AW-1:0]   fe_addr;
    logic            fe_ack;
    logic [DW-1:0]   fe_rdata;

    logic            dm_req;
    logic            dm_we;
    logic [AW-1:0]   dm_addr;
    logic [DW-1:0]   dm_wdata;
    logic [DW/8-1:0] dm_be;
    logic            dm_ack;
    logic [DW-1:0]   dm_rdata;

    logic            mem_req;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW/8-1:0] mem_be;
    logic            mem_ack;
    logic [DW-1:0]   mem_rdata;

    logic            err;

    modport master (
        input  fe_req, fe_addr,
        output fe_ack, fe_rdata,
        input  dm_req, dm_we, dm_addr, dm_wdata, dm_be,
        output dm_ack, dm_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_ack, mem_rdata,
        output err
    );

    modport slave (
        output fe_req, fe_addr,
        input  fe_ack, fe_rdata,
        output dm_req, dm_we, dm_addr, dm_wdata, dm_be,
        input  dm_ack, dm_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_ack, mem_rdata,
        input  err
    );
endinterface

// File: rtl/mem_arb_wdog.sv
// ----------------------------------------------------------------------------
// mem_arb_wdog
// Watchdog for the arbiter's ISSUE phase (used only with MEM_ARB_TIMEOUT_EN).
// Ports:
//   clk, rstn : clock, synchronous active-low reset
//   clear     : zero the count (asserted on entry to ISSUE)
//   count_en  : high while the arbiter sits in ISSUE
//   expire    : high during the TIMEOUT-th consecutive ISSUE cycle
// ----------------------------------------------------------------------------
module mem_arb_wdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rstn,
    input  logic clear,
    input  logic count_en,
    output logic expire
);
    // cnt_q holds the number of ISSUE cycles already completed, so the
    // current cycle is number cnt_q+1 and expiry happens at TIMEOUT-1.
    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (count_en && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = count_en && (cnt_q == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one memory port between the instruction-fetch requester and the
// load/store requester. One transfer at a time: IDLE picks a winner and
// latches its payload, ISSUE holds mem_req until mem_ack, RESP returns a
// one-cycle ack with registered read data.
// Data requests win over fetch, except that after STARVE_LIMIT consecutive
// data grants made while fetch was waiting, fetch is forced through.
// Ports:
//   clk  : system clock
//   rstn : synchronous active-low reset
//   bus  : mem_port_arbiter_if.master (requester and memory handshakes, err)
// Optional build macro MEM_ARB_TIMEOUT_EN: adds a watchdog that aborts a
// transfer after TIMEOUT ISSUE cycles without mem_ack, acking the requester
// with rdata=0 and err=1. Without it ISSUE waits forever and err is 0.
// ----------------------------------------------------------------------------
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW           = AW_DEF,
    parameter int DW           = DW_DEF,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 64
) (
    input  logic                clk,
    input  logic                rstn,
    mem_port_arbiter_if.master  bus
);
    localparam int BW = DW / 8;
    localparam logic [BE_MAX-1:0] BE_ONES_WIDE = be_all_ones(BW);
    localparam logic [BW-1:0]     BE_ONES      = BE_ONES_WIDE[BW-1:0];
    localparam logic [3:0]        LIMIT        = 4'(STARVE_LIMIT);

    state_e          state_q, state_d;
    grant_e          grant_q, grant_d;
    logic [3:0]      streak_q, streak_d;
    logic            mem_we_q, mem_we_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
    logic [BW-1:0]   mem_be_q, mem_be_d;
    logic [DW-1:0]   fe_rdata_q, fe_rdata_d;
    logic [DW-1:0]   dm_rdata_q, dm_rdata_d;
    logic            abort_q, abort_d;
    logic            wdog_clear;
    logic            wdog_expire;
    logic            fe_forced;

`ifdef MEM_ARB_TIMEOUT_EN
    mem_arb_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk      (clk),
        .rstn     (rstn),
        .clear    (wdog_clear),
        .count_en (state_q == ISSUE),
        .expire   (wdog_expire)
    );
`else
    assign wdog_expire = 1'b0;
`endif

    // Fetch overrides a pending data request once the streak is exhausted.
    assign fe_forced = bus.fe_req && (streak_q == LIMIT);

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        streak_d    = streak_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        fe_rdata_d  = fe_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        abort_d     = abort_q;
        wdog_clear  = 1'b0;

        case (state_q)
            IDLE: begin
                if (!bus.fe_req) begin
                    streak_d = '0;
                end
                if (bus.dm_req && !fe_forced) begin
                    grant_d     = DM;
                    mem_we_d    = bus.dm_we;
                    mem_addr_d  = bus.dm_addr;
                    mem_wdata_d = bus.dm_wdata;
                    mem_be_d    = bus.dm_be;
                    // Only grants that make a waiting fetch wait longer count.
                    if (bus.fe_req && (streak_q != LIMIT)) begin
                        streak_d = streak_q + 4'd1;
                    end
                    wdog_clear = 1'b1;
                    state_d    = ISSUE;
                end else if (bus.fe_req) begin
                    grant_d     = FE;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = bus.fe_addr;
                    mem_wdata_d = '0;
                    mem_be_d    = BE_ONES;
                    streak_d    = '0;
                    wdog_clear  = 1'b1;
                    state_d     = ISSUE;
                end
            end

            ISSUE: begin
                // A mem_ack coincident with watchdog expiry completes normally.
                if (bus.mem_ack) begin
                    if (grant_q == FE) begin
                        fe_rdata_d = bus.mem_rdata;
                    end else begin
                        // Stores return zero data to the requester.
                        dm_rdata_d = mem_we_q ? '0 : bus.mem_rdata;
                    end
                    abort_d = 1'b0;
                    state_d = RESP;
                end else if (wdog_expire) begin
                    if (grant_q == FE) begin
                        fe_rdata_d = '0;
                    end else begin
                        dm_rdata_d = '0;
                    end
                    abort_d = 1'b1;
                    state_d = RESP;
                end
            end

            RESP: begin
                abort_d = 1'b0;
                grant_d = NONE;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            grant_q     <= NONE;
            streak_q    <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            fe_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            streak_q    <= streak_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            fe_rdata_q  <= fe_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            abort_q     <= abort_d;
        end
    end

    // All handshake outputs decode directly from flops.
    assign bus.mem_req   = (state_q == ISSUE);
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.fe_ack    = (state_q == RESP) && (grant_q == FE);
    assign bus.dm_ack    = (state_q == RESP) && (grant_q == DM);
    assign bus.fe_rdata  = fe_rdata_q;
    assign bus.dm_rdata  = dm_rdata_q;
`ifdef MEM_ARB_TIMEOUT_EN
    assign bus.err       = (state_q == RESP) && abort_q;
`else
    assign bus.err       = 1'b0;
`endif

endmodule
